// File: rtl/reg_bank.sv
// General-purpose register file: 2**ADDR_WIDTH x DATA_WIDTH, one write port, one read port, r0 reads zero.
// Latency: write lands on the rising edge and is visible right after it; read is combinational (0 cycles).
// Backpressure: none; a write is accepted on every edge where en is high, with no stall or ready.
module reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] read_reg,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  rst_n
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is kept in the array so every index maps directly; it is only
    // ever cleared by reset, and the read mux forces zero for index 0 anyway.
    logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];

    logic w_wr_hit;

    // A write is real only when enabled and aimed at a non-zero index.
    always_comb begin
        w_wr_hit = en && (write_reg != '0);
    end

    // Storage update: reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Combinational read with no write-through bypass: same-index reads see the
    // old value until the edge that performs the write.
    always_comb begin
        read_data = '0;
        if (read_reg != '0) begin
            read_data = r_regs[read_reg];
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset clearing, write/read, r0 discard, enable gating,
// same-cycle read/write ordering, and reset overriding a write mid-stream.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled before the next edge.
module tb_reg_bank;

    logic        clk;
    logic        en;
    logic [4:0]  read_reg;
    logic [31:0] read_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        rst_n;

    int checks;
    int errors;

    reg_bank #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .en         (en),
        .read_reg   (read_reg),
        .read_data  (read_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .rst_n      (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read one index combinationally and compare against the expected value.
    task automatic rd_check(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        read_reg = idx;
        #1;
        checks++;
        assert (read_data === exp)
        else begin
            errors++;
            $error("FAIL %s idx=%0d observed=0x%08h expected=0x%08h", tag, idx, read_data, exp);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        read_reg   = '0;
        write_reg  = '0;
        write_data = '0;

        // Reset, then every index reads 0.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rd_check("reset_clear", 5'(i), 32'd0);

        // Plain write to r15.
        en = 1'b1; write_reg = 5'd15; write_data = 32'd1515;
        tick();
        en = 1'b0;
        rd_check("write_r15", 5'd15, 32'd1515);

        // Write to r0 is discarded.
        en = 1'b1; write_reg = 5'd0; write_data = 32'd999;
        tick();
        en = 1'b0;
        rd_check("r0_discard", 5'd0, 32'd0);
        rd_check("r15_after_r0_wr", 5'd15, 32'd1515);

        // Enabled write to r10, then a gated write to r5.
        en = 1'b1; write_reg = 5'd10; write_data = 32'd111;
        tick();
        en = 1'b0; write_reg = 5'd5; write_data = 32'd6969;
        tick();
        rd_check("write_r10", 5'd10, 32'd111);
        rd_check("gated_r5", 5'd5, 32'd0);
        rd_check("hold_r15", 5'd15, 32'd1515);

        // Same-cycle read/write of r7: old value before edge, new after.
        en = 1'b1; write_reg = 5'd7; write_data = 32'hDEADBEEF;
        rd_check("rw_same_before", 5'd7, 32'd0);
        tick();
        en = 1'b0;
        rd_check("rw_same_after", 5'd7, 32'hDEADBEEF);

        // Fill r1..r31 with their index values.
        for (int i = 1; i < 32; i++) begin
            en = 1'b1; write_reg = 5'(i); write_data = 32'(i);
            tick();
        end
        en = 1'b0;
        rd_check("fill_r1", 5'd1, 32'd1);
        rd_check("fill_r3", 5'd3, 32'd3);
        rd_check("fill_r7", 5'd7, 32'd7);
        rd_check("fill_r31", 5'd31, 32'd31);

        // Reset together with a write to r3: the write is lost, all clear.
        rst_n = 1'b0; en = 1'b1; write_reg = 5'd3; write_data = 32'd77;
        tick();
        rst_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 32; i++) rd_check("reset_mid", 5'(i), 32'd0);

        // Inputs toggling between edges with en low leave state untouched.
        write_reg = 5'd9; write_data = 32'h12345678;
        #1;
        write_reg = 5'd4;
        tick();
        rd_check("idle_r9", 5'd9, 32'd0);
        rd_check("idle_r4", 5'd4, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register file: 32 registers of 32 bits with one synchronous write port and one combinational read port. It sits in the datapath between instruction decode, which supplies register indices, and the execute/write-back stages, which consume operands and return results. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of both data buses.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  write enable; a write occurs only when high at the rising edge.
- read_reg  input  ADDR_WIDTH  read register index.
- read_data  output  DATA_WIDTH  contents of register read_reg.
- write_reg  input  ADDR_WIDTH  write register index.
- write_data  input  DATA_WIDTH  value to write.

Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).

Positional port order: clk, en, read_reg, read_data, write_reg, write_data, rst_n.

## Operation
- Storage: registers r0..r31, each DATA_WIDTH bits.
- Reset, at a rising edge with rst_n=0:
  - every register clears to 0.
  - reset has priority over any write in the same cycle.
- Write, at a rising edge with rst_n=1 and en=1:
  - r[write_reg] <= write_data.
  - all other registers hold their values.
- en=0: no register changes, whatever write_reg and write_data are.
- Register 0:
  - writes to index 0 are silently discarded.
  - r0 always reads 0.
- Read:
  - purely combinational; read_data = r[read_reg], or 0 when read_reg=0.
  - no read enable; read_data always tracks read_reg and the stored contents.
- No X propagation: after reset every read_data value is defined.

## Timing
- Write latency: 1 clock edge. The new value is visible on read_data for the written index immediately after the rising edge that performs the write.
- Read latency: 0 cycles; read_data changes combinationally with read_reg.
- Read and write to the same index in the same cycle:
  - before the edge, read_data shows the old value.
  - after the edge, read_data shows write_data.
  - there is no write-through bypass.
- Reset output value: read_data = 0 for every index, starting the cycle after the reset edge.
- Reset asserted mid-operation: a write presented in the reset cycle is lost; all contents are 0 after that edge.
- Inputs changing between edges have no effect on state; only the value sampled at the rising edge matters.

## Test plan
- Reset, then read all 32 indices -> read_data=0 for every index.
- en=1, write_reg=15, write_data=1515, one edge; then read_reg=15 -> 1515.
- en=1, write_reg=0, write_data=999, one edge; then read_reg=0 -> 0 (write discarded).
- en=1, write_reg=10, write_data=111, one edge; then en=0, write_reg=5, write_data=6969, one edge.
  - read_reg=10 -> 111.
  - read_reg=5 -> 0 (gated write did not occur).
  - read_reg=15 -> still 1515.
- Same-cycle read/write: read_reg=write_reg=7, r7=0, write 0xDEADBEEF.
  - before the edge, read_data=0.
  - after the edge, read_data=0xDEADBEEF.
- Reset mid-stream: after filling r1..r31 with their index values, assert rst_n=0 for one edge together with en=1, write_reg=3, write_data=77.
  - all reads -> 0, including r3.
